// File: rtl/sram_ctrl_pkg.sv
// Shared types and address mapping for the 32-bit-word to 16-bit SRAM controller.
// Optional last-read buffer is enabled with SRAM_CTRL_LAST_READ_BUF_EN.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int WORD_ADDR_W = SRAM_ADDR_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        PAD,
        DONE
    } state_t;

    // Halfword address of the low half of the word at ARM byte address.
    // phys[1:0] drop out and bits above 18 are truncated by the cast.
    function automatic logic [SRAM_ADDR_W-1:0] halfword_base(
        input logic [31:0] address,
        input logic [31:0] base_addr
    );
        logic [31:0] phys;
        phys = address - base_addr;
        return SRAM_ADDR_W'(phys >> 1) & ~SRAM_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/sram_ctrl_read_buf.sv
// Single-entry last-read buffer: remembers the most recently read word so a
// repeated read can complete without touching the SRAM.
module sram_ctrl_read_buf
    import sram_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_ADDR_W-1:0] lookup_addr,
    output logic                   hit,
    output logic [31:0]            hit_data,
    input  logic                   update_en,
    input  logic                   update_is_read,
    input  logic [WORD_ADDR_W-1:0] update_addr,
    input  logic [31:0]            update_data
);

    logic                   valid_reg;
    logic [WORD_ADDR_W-1:0] addr_reg;
    logic [31:0]            data_reg;

    assign hit      = valid_reg && (addr_reg == lookup_addr);
    assign hit_data = data_reg;

    // Reads always (re)fill; writes only refresh a matching entry so the
    // buffer can never return stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else if (update_en) begin
            if (update_is_read) begin
                valid_reg <= 1'b1;
                addr_reg  <= update_addr;
                data_reg  <= update_data;
            end else if (valid_reg && (addr_reg == update_addr)) begin
                data_reg  <= update_data;
            end
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit word requests into two 16-bit SRAM accesses with a fixed
// latency. Define SRAM_CTRL_LAST_READ_BUF_EN to add the last-read buffer.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          ACCESS_CYCLES = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    localparam int             CNT_W   = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] PAD_END = CNT_W'(ACCESS_CYCLES - 2);

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       counter_reg, counter_next;
    logic                   op_write_reg;
    logic [SRAM_ADDR_W-1:0] addr_base_reg;
    logic [31:0]            wdata_reg;
    logic [SRAM_DATA_W-1:0] rdata_lo_reg, rdata_hi_reg;
    logic [31:0]            read_data_reg;

    logic                   start;
    logic                   hit_go;
    logic                   done_entry;
    logic [31:0]            hit_data;
    logic [31:0]            assembled;
    logic [SRAM_DATA_W-1:0] dq_out;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign ready     = ~(wr_en | rd_en) | (state_reg == DONE);
    assign read_data = read_data_reg;

    // Direct from HI to DONE (short latency) the high half is still on the bus.
    assign assembled  = {(state_reg == HI) ? SRAM_DQ : rdata_hi_reg, rdata_lo_reg};
    assign done_entry = ((state_reg == HI) || (state_reg == PAD)) && (state_next == DONE);

`ifdef SRAM_CTRL_LAST_READ_BUF_EN
    logic buf_hit;
    logic [SRAM_ADDR_W-1:0] lookup_base;

    assign lookup_base = halfword_base(address, BASE_ADDR);
    assign hit_go      = rd_en & ~wr_en & buf_hit;

    sram_ctrl_read_buf u_read_buf (
        .clk            (clk),
        .rst            (rst),
        .lookup_addr    (lookup_base[SRAM_ADDR_W-1:1]),
        .hit            (buf_hit),
        .hit_data       (hit_data),
        .update_en      (done_entry),
        .update_is_read (~op_write_reg),
        .update_addr    (addr_base_reg[SRAM_ADDR_W-1:1]),
        .update_data    (op_write_reg ? wdata_reg : assembled)
    );
`else
    assign hit_go   = 1'b0;
    assign hit_data = '0;
`endif

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        start        = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (wr_en | rd_en) begin
                    start        = 1'b1;
                    state_next   = hit_go ? DONE : LO;
                    counter_next = hit_go ? '0 : CNT_W'(1);
                end
            end
            LO: begin
                state_next   = HI;
                counter_next = counter_reg + 1'b1;
            end
            HI, PAD: begin
                state_next   = (counter_reg >= PAD_END) ? DONE : PAD;
                counter_next = counter_reg + 1'b1;
            end
            DONE: begin
                state_next   = IDLE;
                counter_next = '0;
            end
            default: begin
                state_next   = IDLE;
                counter_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_write_reg  <= 1'b0;
            addr_base_reg <= '0;
            wdata_reg     <= '0;
            rdata_lo_reg  <= '0;
            rdata_hi_reg  <= '0;
            read_data_reg <= '0;
        end else begin
            if (start) begin
                op_write_reg  <= wr_en;
                addr_base_reg <= halfword_base(address, BASE_ADDR);
                wdata_reg     <= write_data;
            end
            if ((state_reg == LO) && !op_write_reg)
                rdata_lo_reg <= SRAM_DQ;
            if ((state_reg == HI) && !op_write_reg)
                rdata_hi_reg <= SRAM_DQ;
            if (done_entry && !op_write_reg)
                read_data_reg <= assembled;
            else if (start && hit_go)
                read_data_reg <= hit_data;
        end
    end

    // The SRAM drives DQ whenever WE_N is high, so we only drive it while
    // actively strobing a write.
    always_comb begin
        SRAM_WE_N = 1'b1;
        SRAM_ADDR = '0;
        dq_out    = wdata_reg[SRAM_DATA_W-1:0];
        if (state_reg == LO) begin
            SRAM_WE_N = ~op_write_reg;
            SRAM_ADDR = addr_base_reg;
        end else if (state_reg == HI) begin
            SRAM_WE_N = ~op_write_reg;
            SRAM_ADDR = addr_base_reg | SRAM_ADDR_W'(1);
            dq_out    = wdata_reg[31:SRAM_DATA_W];
        end
    end

    assign SRAM_DQ = SRAM_WE_N ? {SRAM_DATA_W{1'bz}} : dq_out;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit SRAM model;
// expects the short repeated-read latency when SRAM_CTRL_LAST_READ_BUF_EN is set.
module tb_sram_controller;

    localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_BOTH = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;

    logic [15:0] mem [0:255] = '{default: 16'h0000};

    int n_checks = 0;
    int n_fail   = 0;
    int bus_viol = 0;
    logic        cur_is_read = 1'b0;
    logic [31:0] last_rd = '0;
    logic        buf_valid = 1'b0;
    logic [16:0] buf_word = '0;

    vec_t vecs [12];

    always #5 clk = ~clk;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_OE_N  (sram_oe_n)
    );

    // SRAM model: drives the bus whenever WE_N is high, writes on the clock while WE_N low.
    assign sram_dq = sram_we_n ? mem[sram_addr[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_we_n)
            mem[sram_addr[7:0]] <= sram_dq;
    end

    always @(negedge clk) begin
        if (cur_is_read && !sram_we_n)
            bus_viol++;
        if (sram_we_n && (sram_dq !== mem[sram_addr[7:0]]))
            bus_viol++;
        if (!sram_we_n && (^sram_dq === 1'bx))
            bus_viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_idx(input logic [31:0] a);
        logic [31:0] p;
        p = (a - 32'd1024) >> 1;
        return p[7:0] & 8'hFE;
    endfunction

    function automatic logic [16:0] word_of(input logic [31:0] a);
        logic [31:0] p;
        p = (a - 32'd1024) >> 2;
        return p[16:0];
    endfunction

    task automatic do_access(input int idx, input vec_t v);
        int n;
        int exp_lat;
        logic [7:0] hw;
        hw = mem_idx(v.addr);
        exp_lat = 5;
`ifdef SRAM_CTRL_LAST_READ_BUF_EN
        if (v.op == OP_RD && buf_valid && buf_word == word_of(v.addr))
            exp_lat = 1;
`endif
        @(posedge clk); #1;
        wr_en       = (v.op != OP_RD);
        rd_en       = (v.op != OP_WR);
        address     = v.addr;
        write_data  = v.wdata;
        cur_is_read = (v.op == OP_RD);
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ready) break;
        end
        check("latency", n, exp_lat);
        check("we_n_in_done", {31'b0, sram_we_n}, 32'd1);
        if (v.op == OP_RD) begin
            check("read_data", read_data, v.exp_rd);
            last_rd   = v.exp_rd;
            buf_valid = 1'b1;
            buf_word  = word_of(v.addr);
        end else begin
            check("read_data_hold", read_data, last_rd);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        cur_is_read = 1'b0;
        if (v.op != OP_RD) begin
            check("mem_lo", {16'h0, mem[hw]}, {16'h0, v.wdata[15:0]});
            check("mem_hi", {16'h0, mem[hw + 8'd1]}, {16'h0, v.wdata[31:16]});
        end
        $display("txn %0d op=%0d addr=%h wdata=%h read_data=%h cycles=%0d",
                 idx, v.op, v.addr, v.wdata, read_data, n);
    endtask

    initial begin
        vecs[0]  = '{OP_WR,   32'd1024,            32'hDEADBEEF, 32'h0};
        vecs[1]  = '{OP_RD,   32'd1024,            32'h0,        32'hDEADBEEF};
        vecs[2]  = '{OP_WR,   32'd1028,            32'h12345678, 32'h0};
        vecs[3]  = '{OP_RD,   32'd1028,            32'h0,        32'h12345678};
        vecs[4]  = '{OP_RD,   32'd1024,            32'h0,        32'hDEADBEEF};
        vecs[5]  = '{OP_BOTH, 32'd1032,            32'hA5A5A5A5, 32'h0};
        vecs[6]  = '{OP_RD,   32'd1032,            32'h0,        32'hA5A5A5A5};
        vecs[7]  = '{OP_RD,   32'd1024,            32'h0,        32'hDEADBEEF};
        vecs[8]  = '{OP_WR,   32'd1024,            32'h00000000, 32'h0};
        vecs[9]  = '{OP_RD,   32'd1024,            32'h0,        32'h00000000};
        vecs[10] = '{OP_RD,   32'd1040,            32'h0,        32'h00002222};
        vecs[11] = '{OP_RD,   32'd1024 + 32'h80006, 32'h0,       32'h12345678};

        // Reset state
        #2;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        check("rst_addr", {14'b0, sram_addr}, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset in the middle of a write: only the low half lands.
        @(posedge clk); #1;
        wr_en = 1'b1;
        address = 32'd1040;
        write_data = 32'h11112222;
        @(negedge clk);
        @(negedge clk);
        check("lo_addr", {14'b0, sram_addr}, 32'd8);
        check("lo_dq", {16'b0, sram_dq}, 32'h2222);
        @(negedge clk);
        check("hi_we_n", {31'b0, sram_we_n}, 32'd0);
        check("hi_addr", {14'b0, sram_addr}, 32'd9);
        check("hi_dq", {16'b0, sram_dq}, 32'h1111);
        #1 rst = 1'b1;
        #1;
        check("abort_we_n", {31'b0, sram_we_n}, 32'd1);
        check("abort_ready", {31'b0, ready}, 32'd0);
        check("abort_addr", {14'b0, sram_addr}, 32'd0);
        wr_en = 1'b0;
        #1;
        check("abort_ready_idle", {31'b0, ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("partial_lo", {16'b0, mem[8]}, 32'h2222);
        check("partial_hi", {16'b0, mem[9]}, 32'h0000);
        buf_valid = 1'b0;

        for (int i = 0; i < 12; i++)
            do_access(i, vecs[i]);

        // No request: ready stays high.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", {31'b0, ready}, 32'd1);
        end

        // Request dropped mid-access: latched write still finishes.
        @(posedge clk); #1;
        wr_en = 1'b1;
        address = 32'd1036;
        write_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("dropped_lo", {16'b0, mem[6]}, 32'hF00D);
        check("dropped_hi", {16'b0, mem[7]}, 32'hCAFE);
        check("dropped_read_data", read_data, last_rd);

        check("bus_rules", bus_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
